// File: rtl/ips2l_pcie_dma_rx_mwr_parser.sv
// RX TLP parser: decodes MWr (3DW/4DW), realigns payload to lane 0, stores the
// whole TLP, then replays it as one gap-free burst framed by o_wr_start.
module ips2l_pcie_dma_rx_mwr_parser #(
  parameter int unsigned FIFO_AW    = 6,
  parameter int unsigned GAP_CYCLES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_axis_master_tvalid,
  output logic         o_axis_master_tready,
  input  logic [127:0] i_axis_master_tdata,
  input  logic [3:0]   i_axis_master_tkeep,
  input  logic         i_axis_master_tlast,
  input  logic [7:0]   i_axis_master_tuser,
  output logic         o_wr_start,
  output logic [9:0]   o_length,
  output logic [7:0]   o_dwbe,
  output logic [127:0] o_data,
  output logic [3:0]   o_dw_vld,
  output logic [63:0]  o_addr,
  output logic [1:0]   o_bar_hit,
  output logic         o_tlp_drop
);

  localparam int unsigned CAP_DW = 4 * (2 ** FIFO_AW);

  typedef enum logic [2:0] {
    S_IDLE, S_RECV, S_DROP, S_FLUSH, S_EMIT_PRE, S_EMIT, S_GAP
  } state_t;

  state_t state, state_n;

  logic [31:0]        dw0, dw1, dw2, dw3;
  logic               hs, hdr_4dw, hdr_mwr, hdr_ok;
  logic [10:0]        hdr_len;
  logic [63:0]        hdr_addr;
  logic [1:0]         hdr_bar;
  logic [2:0]         keep_cnt;
  logic [11:0]        cnt_sum;
  logic               err_sum;

  logic               is4_q, err_q, drop_q, drop_n;
  logic [10:0]        len_q, cnt_q;
  logic [7:0]         dwbe_q, gap_cnt;
  logic [63:0]        addr_q;
  logic [1:0]         bar_q;
  logic [31:0]        carry_q;
  logic [9:0]         emit_left;

  logic               wr_en, rd_en;
  logic [127:0]       wr_data, rd_data;
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr, rd_addr;
  logic [127:0]       mem [2**FIFO_AW];

  logic               unused_bits;

  assign {dw3, dw2, dw1, dw0} = i_axis_master_tdata;
  assign hs = i_axis_master_tvalid && o_axis_master_tready;
  assign o_axis_master_tready = (state == S_IDLE) || (state == S_RECV) || (state == S_DROP);
  assign unused_bits = ^{i_axis_master_tuser[7:6], dw0[31], dw0[23:15], dw0[13:10],
                         dw1[31:8], dw3[1:0]};

  always_comb begin
    hdr_4dw  = dw0[29];
    hdr_mwr  = dw0[30] && (dw0[28:24] == 5'b00000);
    hdr_len  = (dw0[9:0] == 10'd0) ? 11'd1024 : {1'b0, dw0[9:0]};
    hdr_ok   = hdr_mwr && !dw0[14] && (32'(hdr_len) <= CAP_DW);
    hdr_addr = hdr_4dw ? {dw2, dw3[31:2], 2'b00} : {32'h0, dw2[31:2], 2'b00};
    if (i_axis_master_tuser[0])      hdr_bar = 2'd0;
    else if (i_axis_master_tuser[1]) hdr_bar = 2'd1;
    else if (i_axis_master_tuser[2]) hdr_bar = 2'd2;
    else                             hdr_bar = 2'd3;
    keep_cnt = {2'b00, i_axis_master_tkeep[0]} + {2'b00, i_axis_master_tkeep[1]}
             + {2'b00, i_axis_master_tkeep[2]} + {2'b00, i_axis_master_tkeep[3]};
    cnt_sum  = {1'b0, cnt_q} + {9'b0, keep_cnt};
    // Once more DWs arrive than declared, stop writing so the buffer cannot overrun.
    err_sum  = err_q || (cnt_sum > {1'b0, len_q});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    wr_en   = 1'b0;
    wr_data = '0;
    drop_n  = 1'b0;
    unique case (state)
      S_IDLE: if (hs) begin
        if (hdr_ok && !hdr_4dw && hdr_len == 11'd1 && i_axis_master_tlast) begin
          wr_en   = 1'b1;
          wr_data = {96'h0, dw3};
          state_n = S_EMIT_PRE;
        end else if (i_axis_master_tlast) begin
          drop_n = hdr_mwr;
        end else if (hdr_ok) begin
          state_n = S_RECV;
        end else begin
          drop_n  = hdr_mwr;
          state_n = S_DROP;
        end
      end
      S_RECV: if (hs) begin
        wr_en   = !err_sum;
        wr_data = is4_q ? i_axis_master_tdata : {dw2, dw1, dw0, carry_q};
        if (i_axis_master_tlast) begin
          if (err_sum || cnt_sum[10:0] != len_q) begin
            drop_n  = 1'b1;
            state_n = S_IDLE;
          end else if (!is4_q && len_q[1:0] == 2'b01) begin
            state_n = S_FLUSH;
          end else begin
            state_n = S_EMIT_PRE;
          end
        end
      end
      S_DROP:     if (hs && i_axis_master_tlast) state_n = S_IDLE;
      S_FLUSH: begin
        wr_en   = 1'b1;
        wr_data = {96'h0, carry_q};
        state_n = S_EMIT_PRE;
      end
      S_EMIT_PRE: state_n = S_EMIT;
      S_EMIT:     if (emit_left == 10'd1) state_n = S_GAP;
      S_GAP:      if (gap_cnt == 8'(GAP_CYCLES - 1)) state_n = S_IDLE;
      default:    state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      is4_q   <= 1'b0;
      err_q   <= 1'b0;
      len_q   <= '0;
      cnt_q   <= '0;
      dwbe_q  <= '0;
      addr_q  <= '0;
      bar_q   <= '0;
      carry_q <= '0;
      drop_q  <= 1'b0;
      wr_ptr  <= '0;
    end else begin
      drop_q <= drop_n;
      if (state == S_IDLE && hs) begin
        is4_q   <= hdr_4dw;
        err_q   <= 1'b0;
        len_q   <= hdr_len;
        cnt_q   <= hdr_4dw ? 11'd0 : {10'b0, i_axis_master_tkeep[3]};
        dwbe_q  <= dw1[7:0];
        addr_q  <= hdr_addr;
        bar_q   <= hdr_bar;
        carry_q <= dw3;
      end else if (state == S_RECV && hs) begin
        cnt_q   <= cnt_sum[10:0];
        err_q   <= err_sum;
        carry_q <= dw3;
      end
      // Pointer rewinds whenever the FSM returns to IDLE, so each TLP starts at 0.
      if (state_n == S_IDLE) wr_ptr <= '0;
      else if (wr_en)        wr_ptr <= wr_ptr + 1'b1;
    end
  end

  assign rd_en   = (state == S_EMIT_PRE) || (state == S_EMIT);
  assign rd_addr = (state == S_EMIT_PRE) ? '0 : rd_ptr;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_length  <= '0;
      o_dwbe    <= '0;
      o_addr    <= '0;
      o_bar_hit <= '0;
      emit_left <= '0;
      rd_ptr    <= '0;
      gap_cnt   <= '0;
    end else begin
      if (state == S_EMIT_PRE) begin
        o_length  <= len_q[9:0];
        o_dwbe    <= dwbe_q;
        o_addr    <= addr_q;
        o_bar_hit <= bar_q;
        emit_left <= 10'((12'(len_q) + 12'd3) >> 2);
        rd_ptr    <= rd_addr + 1'b1;
      end else if (state == S_EMIT) begin
        emit_left <= emit_left - 10'd1;
        rd_ptr    <= rd_addr + 1'b1;
      end
      gap_cnt <= (state == S_GAP) ? gap_cnt + 8'd1 : 8'd0;
    end
  end

  always_comb begin
    o_dw_vld = '0;
    if (state == S_EMIT) begin
      o_dw_vld = 4'b1111;
      if (emit_left == 10'd1) begin
        unique case (o_length[1:0])
          2'd1:    o_dw_vld = 4'b0001;
          2'd2:    o_dw_vld = 4'b0011;
          2'd3:    o_dw_vld = 4'b0111;
          default: o_dw_vld = 4'b1111;
        endcase
      end
    end
  end

  assign o_wr_start = (state == S_EMIT);
  assign o_tlp_drop = drop_q;
  assign o_data     = rd_data & {{32{o_dw_vld[3]}}, {32{o_dw_vld[2]}},
                                 {32{o_dw_vld[1]}}, {32{o_dw_vld[0]}}};

endmodule

// File: tb/tb_ips2l_pcie_dma_rx_mwr_parser.sv
// Scoreboard bench for the RX MWr parser: expected burst beats are queued as each
// TLP is driven and popped as the DUT replays them.
`timescale 1ns/1ps
module tb_ips2l_pcie_dma_rx_mwr_parser;

  localparam int unsigned FIFO_AW    = 6;
  localparam int unsigned GAP_CYCLES = 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         tvalid, tready, tlast;
  logic [127:0] tdata;
  logic [3:0]   tkeep;
  logic [7:0]   tuser;
  logic         o_wr_start, o_tlp_drop;
  logic [9:0]   o_length;
  logic [7:0]   o_dwbe;
  logic [127:0] o_data;
  logic [3:0]   o_dw_vld;
  logic [63:0]  o_addr;
  logic [1:0]   o_bar_hit;

  ips2l_pcie_dma_rx_mwr_parser #(.FIFO_AW(FIFO_AW), .GAP_CYCLES(GAP_CYCLES)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_axis_master_tvalid(tvalid), .o_axis_master_tready(tready),
    .i_axis_master_tdata(tdata), .i_axis_master_tkeep(tkeep),
    .i_axis_master_tlast(tlast), .i_axis_master_tuser(tuser),
    .o_wr_start(o_wr_start), .o_length(o_length), .o_dwbe(o_dwbe),
    .o_data(o_data), .o_dw_vld(o_dw_vld), .o_addr(o_addr),
    .o_bar_hit(o_bar_hit), .o_tlp_drop(o_tlp_drop)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [127:0] data;
    logic [3:0]   vld;
    logic [63:0]  addr;
    logic [9:0]   len;
    logic [7:0]   dwbe;
    logic [1:0]   bar;
    bit           first;
    bit           last;
    int unsigned  lat;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  int          checks = 0, errors = 0;
  int          drops_seen = 0, exp_drops = 0;
  int unsigned hs_cyc = 0, gap_n = 0;
  bit          mid = 0, in_gap = 0, watch_rdy = 0, rdy_low = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [1:0] bar_enc(input logic [5:0] b);
    if (b[0])      return 2'd0;
    else if (b[1]) return 2'd1;
    else if (b[2]) return 2'd2;
    else           return 2'd3;
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      mid = 0;
      in_gap = 0;
    end else begin
      if (o_tlp_drop) drops_seen++;
      if (watch_rdy && !tready) rdy_low = 1;
      if (in_gap) begin
        if (!tready) gap_n++;
        else begin
          check("gap_cycles", gap_n, GAP_CYCLES);
          in_gap = 0;
        end
      end
      if (mid) check("gap_free", o_wr_start, 1);
      if (o_wr_start) begin
        check("beat_expected", sb.size() != 0, 1);
        mid = 0;
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("data", o_data, e.data);
          check("dw_vld", o_dw_vld, e.vld);
          check("addr", o_addr, e.addr);
          check("length", o_length, e.len);
          check("dwbe", o_dwbe, e.dwbe);
          check("bar_hit", o_bar_hit, e.bar);
          check("tready_low", tready, 0);
          if (e.first) check("latency", cyc - hs_cyc, e.lat);
          mid = !e.last;
          if (e.last) begin
            in_gap = 1;
            gap_n = 0;
          end
        end
      end else begin
        mid = 0;
        check("idle_zero", o_data | 128'(o_dw_vld), 0);
      end
    end
  end

  task automatic drive_beat(input logic [127:0] data, input logic [3:0] keep,
                            input bit last, input logic [7:0] user);
    bit done = 0;
    tvalid = 1'b1; tdata = data; tkeep = keep; tlast = last; tuser = user;
    for (int i = 0; i < 1000 && !done; i++) begin
      @(negedge clk);
      if (tready) begin
        done = 1;
        if (last) hs_cyc = cyc;
      end
    end
    check("tready_wait", done, 1);
    if (done) @(posedge clk);
    #1;
    tvalid = 1'b0; tlast = 1'b0;
  endtask

  // mode: 0 = silently consumed, 1 = replayed burst, 2 = dropped with pulse
  task automatic send_tlp(input logic [7:0] ft, input bit ep, input logic [9:0] len_f,
                          input int unsigned ndw, input logic [63:0] addr, input logic [7:0] be,
                          input logic [5:0] bar, input logic [31:0] pbase,
                          input int unsigned gap, input int mode);
    bit          is4 = ft[5];
    int unsigned L = (len_f == 10'd0) ? 1024 : int'(len_f);
    int unsigned nb = (L + 3) / 4;
    int unsigned pidx;
    logic [31:0] d [4];
    logic [3:0]  keep;
    exp_t        x;
    if (mode == 1) begin
      for (int unsigned b = 0; b < nb; b++) begin
        x.data = '0;
        x.vld  = '0;
        for (int unsigned k = 0; k < 4; k++)
          if (4 * b + k < L) begin
            x.data[32*k +: 32] = pbase + 32'(4 * b + k);
            x.vld[k] = 1'b1;
          end
        x.addr  = is4 ? {addr[63:2], 2'b00} : {32'h0, addr[31:2], 2'b00};
        x.len   = len_f;
        x.dwbe  = be;
        x.bar   = bar_enc(bar);
        x.first = (b == 0);
        x.last  = (b == nb - 1);
        x.lat   = (!is4 && (L % 4 == 1) && L > 1) ? 3 : 2;
        sb.push_back(x);
      end
    end
    if (mode == 2) exp_drops++;
    d[0] = {ft, 8'h00, 1'b0, ep, 4'h0, len_f};
    d[1] = {16'h0100, 8'h00, be};
    if (is4) begin
      d[2] = addr[63:32]; d[3] = {addr[31:2], 2'b00}; pidx = 0; keep = 4'hF;
    end else begin
      d[2] = {addr[31:2], 2'b00};
      d[3] = (ndw > 0) ? pbase : 32'h0;
      pidx = (ndw > 0) ? 1 : 0;
      keep = (ndw > 0) ? 4'hF : 4'h7;
    end
    drive_beat({d[3], d[2], d[1], d[0]}, keep, pidx >= ndw, {2'b00, bar});
    while (pidx < ndw) begin
      repeat (gap) begin @(posedge clk); #1; end
      keep = '0;
      for (int k = 0; k < 4; k++) begin
        if (pidx < ndw) begin
          d[k] = pbase + pidx; keep[k] = 1'b1; pidx++;
        end else d[k] = 32'h0;
      end
      drive_beat({d[3], d[2], d[1], d[0]}, keep, pidx >= ndw, {2'b00, bar});
    end
  endtask

  task automatic drain();
    int unsigned n = 0;
    while ((sb.size() != 0 || in_gap || mid) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("drain", sb.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    tvalid = 1'b0; tdata = '0; tkeep = '0; tlast = 1'b0; tuser = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_wr_start", o_wr_start, 0);
    check("rst_drop", o_tlp_drop, 0);
    check("rst_length", o_length, 0);
    check("rst_addr", o_addr, 0);
    check("rst_dw_vld", o_dw_vld, 0);
    check("rst_tready", tready, 1);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // 3DW Length=1, payload in header DW3, single beat with tlast
    send_tlp(8'h40, 0, 10'd1, 1, 64'h104, 8'h0F, 6'b000001, 32'hA5A5A5A5, 0, 1);
    drain();
    // 4DW Length=6, BAR1
    send_tlp(8'h60, 0, 10'd6, 6, 64'h1_0000_0010, 8'hFF, 6'b000010, 32'h1000_0000, 0, 1);
    drain();
    // 3DW Length=8 with 3-cycle tvalid gaps
    send_tlp(8'h40, 0, 10'd8, 8, 64'h2000, 8'hF1, 6'b000100, 32'h3000_0000, 3, 1);
    drain();

    // MRd, poisoned MWr, oversize MWr: all consumed, two drop pulses
    watch_rdy = 1; rdy_low = 0;
    send_tlp(8'h00, 0, 10'd1, 0, 64'h3000, 8'h0F, 6'b000001, 32'h0, 0, 0);
    send_tlp(8'h40, 1, 10'd2, 2, 64'h3100, 8'hFF, 6'b000001, 32'h4000_0000, 0, 2);
    send_tlp(8'h40, 0, 10'd0, 8, 64'h3200, 8'hFF, 6'b000001, 32'h5000_0000, 0, 2);
    repeat (4) @(posedge clk);
    #1;
    watch_rdy = 0;
    check("rdy_held", rdy_low, 0);
    check("drops_a", drops_seen, exp_drops);

    // Short payload, then a valid 4DW MWr to a non-BAR0..2 hit
    send_tlp(8'h40, 0, 10'd4, 3, 64'h3300, 8'hFF, 6'b000001, 32'h6000_0000, 0, 2);
    send_tlp(8'h60, 0, 10'd5, 5, 64'h0000_0001_2345_6788, 8'h3C, 6'b100000, 32'h7000_0000, 1, 1);
    drain();
    check("drops_b", drops_seen, exp_drops);

    // Reset in the middle of RECV
    drive_beat({32'h8000_0000, 32'h0000_4000, 32'h0100_00FF, 32'h4000_0008}, 4'hF, 0, 8'h01);
    drive_beat({32'h8000_0004, 32'h8000_0003, 32'h8000_0002, 32'h8000_0001}, 4'hF, 0, 8'h01);
    @(negedge clk) rst_n = 1'b0;
    #1;
    check("mid_rst_wr_start", o_wr_start, 0);
    check("mid_rst_length", o_length, 0);
    check("mid_rst_addr", o_addr, 0);
    check("mid_rst_dwbe", o_dwbe, 0);
    check("mid_rst_bar", o_bar_hit, 0);
    check("mid_rst_data", o_data, 0);
    check("mid_rst_drop", o_tlp_drop, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    // 3DW Length=5 needs a flush beat
    send_tlp(8'h40, 0, 10'd5, 5, 64'h5004, 8'hFF, 6'b000100, 32'h9000_0000, 0, 1);
    drain();
    send_tlp(8'h40, 0, 10'd13, 13, 64'hABCD_0100, 8'h7E, 6'b000001, $urandom, 1, 1);
    drain();
    send_tlp(8'h60, 0, 10'd16, 16, 64'hFFFF_0000_0000_0040, 8'hFF, 6'b000010, $urandom, 0, 1);
    drain();
    send_tlp(8'h40, 0, 10'd1, 1, 64'h8, 8'h01, 6'b000001, 32'h1234_5678, 0, 1);
    drain();

    repeat (4) @(posedge clk);
    #1;
    check("drops_final", drops_seen, exp_drops);
    check("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ips2l_pcie_dma_rx_mwr_parser.md
Name: ips2l_pcie_dma_rx_mwr_parser

Overview:
Receive-side TLP parser. It sits between the PCIe core AXI-stream master (RX) interface and the DMA BAR write controller. It accepts 128-bit RX TLPs and decodes Memory Write requests (3DW and 4DW header). It realigns the payload so the first payload DW sits in lane 0, buffers the whole TLP (store-and-forward), then replays it as one gap-free burst framed by o_wr_start. All other TLPs are consumed and discarded.

Parameters:
FIFO_AW, 6, log2 of payload buffer depth in 128-bit beats; capacity = 4*2^FIFO_AW DW.
GAP_CYCLES, 2, minimum cycles o_wr_start stays low between bursts (>=1).

Ports:
clk  input  1  core user clock (gen1 62.5MHz, gen2 125MHz)
rst_n  input  1  asynchronous active-low reset
i_axis_master_tvalid  input  1  RX beat valid
o_axis_master_tready  output  1  RX beat accept
i_axis_master_tdata  input  128  RX beat; DW0 = [31:0]; header fields at PCIe-spec bit positions within each DW
i_axis_master_tkeep  input  4  per-DW valid (informational; payload count taken from Length)
i_axis_master_tlast  input  1  last beat of TLP
i_axis_master_tuser  input  8  [5:0] one-hot BAR0..BAR5 hit; [7:6] unused
o_wr_start  output  1  high for every beat of a replayed MWr burst
o_length  output  10  TLP Length field
o_dwbe  output  8  {Last BE, First BE}
o_data  output  128  packed payload beat
o_dw_vld  output  4  per-lane valid of o_data
o_addr  output  64  byte address (bits [1:0] = 0)
o_bar_hit  output  2  0=BAR0, 1=BAR1, 2=BAR2, 3=any other
o_tlp_drop  output  1  one-cycle pulse per discarded MWr (oversize/malformed/poisoned)

Behaviour:
- Clock is clk. Reset is rst_n: asynchronous, active-low.
- Reset values: all outputs 0 except o_axis_master_tready, which is 1 once in IDLE. State = IDLE, buffer empty.
- Reset mid-operation discards any partial or stored TLP. The first beat accepted after reset is treated as a header.
- Header decode on the first beat: fmt = DW0[30:29], type = DW0[28:24], EP = DW0[14], Length = DW0[9:0] (0 means 1024).
- MWr is fmt 2'b10 (3DW) or 2'b11 (4DW) with type 5'b00000.
- Address: 3DW uses {32'b0, DW2[31:2], 2'b0}. 4DW uses {DW2, DW3[31:2], 2'b0}.
- dwbe = DW1[7:0]. bar_hit is encoded from tuser[5:0] on the header beat.
- States:
  - IDLE: tready=1. On header beat:
    - MWr with EP=0 and Length <= capacity: go to RECV.
    - MWr otherwise: go to DROP and pulse o_tlp_drop.
    - Non-MWr: go to DROP, no pulse.
    - If the header beat also has tlast: 3DW length-1 MWr goes to EMIT_PRE; any dropped TLP stays in IDLE.
  - RECV: tready=1; tvalid gaps are allowed.
    - 3DW: the beat-0 DW3 seeds a carry register. Each stored beat = {in.DW2, in.DW1, in.DW0, carry}, then carry <= in.DW3. A flush beat is written after tlast if DWs remain.
    - 4DW: beats are stored unchanged.
    - Stored DW count is tracked. At tlast, if the count != Length: empty the buffer, pulse o_tlp_drop, go to IDLE. Otherwise go to EMIT_PRE.
  - DROP: tready=1; consume beats until tlast, then go to IDLE.
  - EMIT_PRE: tready=0. Latch o_length/o_dwbe/o_addr/o_bar_hit; these hold until the next EMIT_PRE. Issue the first buffer read. Go to EMIT after 1 cycle.
  - EMIT: tready=0. o_wr_start=1 for exactly ceil(Length/4) consecutive cycles with one beat per cycle.
    - o_dw_vld = 4'b1111, except the final beat, which takes Length[1:0]: 1 -> 0001, 2 -> 0011, 3 -> 0111, 0 -> 1111.
    - After the final beat, go to GAP.
  - GAP: tready=0, o_wr_start=0 for GAP_CYCLES cycles, then go to IDLE.
- o_data and o_dw_vld are 0 whenever o_wr_start=0.
- Latency: o_wr_start first rises 2 cycles after the tlast handshake cycle, or 3 cycles if a 3DW flush beat is needed.
- Only one TLP is buffered at a time. Buffer pointers are FIFO_AW bits and reset to 0 per TLP, so no wrap-around across TLPs.
- Length arithmetic is done in 11 bits so that 1024 is representable.

Test Plan:
- 3DW MWr, Length=1, addr 0x0000_0104, BE 0x0F, single beat with tlast, payload 0xA5A5A5A5 in DW3 -> o_wr_start high 1 cycle; o_data[31:0]=0xA5A5A5A5, o_dw_vld=0001, o_addr=0x104, o_dwbe=0x0F.
- 4DW MWr, Length=6, addr 0x1_0000_0010, BAR1 hit, 2 payload beats -> o_wr_start high 2 cycles, o_dw_vld 1111 then 0011, o_addr=0x1_0000_0010, o_bar_hit=1.
- 3DW MWr, Length=8, tvalid deasserted 3 cycles between beats -> 2 gap-free output beats with DWs packed in order 0..7, then o_wr_start low for exactly 2 cycles (GAP_CYCLES).
- MRd followed by MWr with EP=1, then MWr with Length=0 (1024 DW) at FIFO_AW=6 -> no o_wr_start; o_tlp_drop pulses twice; tready stays 1 throughout.
- MWr that declares Length=4 but delivers 3 DW -> o_tlp_drop pulse, no burst; the next valid MWr is replayed correctly.
- rst_n asserted mid-RECV -> all outputs 0 immediately; a fresh MWr after release replays correctly.
